// File: rtl/mips_alu.sv
// mips_alu: 32-bit MIPS integer ALU for the execute stage, with HI/LO next-value logic.
// Latency: all results are combinational (zero cycles); only OverflowSticky is registered.
// Backpressure: none; no handshake, outputs follow the inputs every cycle.
//
// Ports:
//   CLK, RESET        clock (rising edge) and asynchronous active-low reset
//   A, B              operands (rs, rt/immediate); shiftAmount is the immediate shamt
//   ALU_control       6-bit operation select
//   HI_IN, LO_IN      current HI/LO; HI_OUT, LO_OUT propose the next HI/LO
//   aluResult         main result; Overflow flags signed ADD/SUB overflow
//   OverflowSticky    set by any Overflow on a clock edge, cleared only by reset
//
// Build option: define MULDIV_EN to implement MULT/MULTU/DIV/DIVU. Without it those
// four codes give aluResult=0 and pass HI/LO through; MFHI/MFLO/MTHI/MTLO stay.
module mips_alu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALU_control,
  input  logic [4:0]  shiftAmount,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  output logic [31:0] aluResult,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT,
  output logic        Overflow,
  output logic        OverflowSticky
);

  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_SLLV  = 6'b000100;
  localparam logic [5:0] OP_SRLV  = 6'b000110;
  localparam logic [5:0] OP_SRAV  = 6'b000111;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_PASSB = 6'b111111;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic [4:0]  var_sh;

  assign sum    = A + B;
  assign diff   = A - B;
  // Signed overflow: operand signs agree (add) / disagree (sub) and the result sign flips away from A.
  assign add_ovf = (A[31] == B[31]) && (sum[31] != A[31]);
  assign sub_ovf = (A[31] != B[31]) && (diff[31] != A[31]);
  assign var_sh  = A[4:0];

`ifdef MULDIV_EN
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] bm_safe;
  logic [31:0] qu;
  logic [31:0] ru;
  logic [31:0] qm;
  logic [31:0] rm;
  logic [31:0] qs;
  logic [31:0] rs;

  // Low 64 bits of the product of sign-extended operands equal the signed 64-bit product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisors forced non-zero so the dividers never see zero; the result is discarded then.
  assign b_safe  = (B == 32'd0) ? 32'd1 : B;
  assign qu      = A / b_safe;
  assign ru      = A % b_safe;

  // Signed divide on magnitudes. 0x80000000 has magnitude 0x80000000 as unsigned, so
  // 0x80000000 / -1 yields quotient 0x80000000 and remainder 0 without special casing.
  assign a_mag   = A[31] ? (~A + 32'd1) : A;
  assign b_mag   = B[31] ? (~B + 32'd1) : B;
  assign bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign qm      = a_mag / bm_safe;
  assign rm      = a_mag % bm_safe;
  assign qs      = (A[31] ^ B[31]) ? (~qm + 32'd1) : qm;
  assign rs      = A[31] ? (~rm + 32'd1) : rm;
`endif

  always_comb begin
    // Undefined codes fall through to A+B for the load/store address path.
    aluResult = sum;
    HI_OUT    = HI_IN;
    LO_OUT    = LO_IN;
    Overflow  = 1'b0;
    case (ALU_control)
      OP_ADD:   begin aluResult = sum;  Overflow = add_ovf; end
      OP_ADDU:  aluResult = sum;
      OP_SUB:   begin aluResult = diff; Overflow = sub_ovf; end
      OP_SUBU:  aluResult = diff;
      OP_AND:   aluResult = A & B;
      OP_OR:    aluResult = A | B;
      OP_XOR:   aluResult = A ^ B;
      OP_NOR:   aluResult = ~(A | B);
      OP_SLT:   aluResult = {31'd0, $signed(A) < $signed(B)};
      OP_SLTU:  aluResult = {31'd0, A < B};
      OP_SLL:   aluResult = B << shiftAmount;
      OP_SRL:   aluResult = B >> shiftAmount;
      OP_SRA:   aluResult = $unsigned($signed(B) >>> shiftAmount);
      OP_SLLV:  aluResult = B << var_sh;
      OP_SRLV:  aluResult = B >> var_sh;
      OP_SRAV:  aluResult = $unsigned($signed(B) >>> var_sh);
      OP_LUI:   aluResult = {B[15:0], 16'h0000};
      OP_PASSB: aluResult = B;
      OP_MFHI:  aluResult = HI_IN;
      OP_MFLO:  aluResult = LO_IN;
      OP_MTHI:  begin aluResult = 32'd0; HI_OUT = A; end
      OP_MTLO:  begin aluResult = 32'd0; LO_OUT = A; end
      OP_MULT: begin
        aluResult = 32'd0;
`ifdef MULDIV_EN
        {HI_OUT, LO_OUT} = prod_s;
`endif
      end
      OP_MULTU: begin
        aluResult = 32'd0;
`ifdef MULDIV_EN
        {HI_OUT, LO_OUT} = prod_u;
`endif
      end
      OP_DIV: begin
        aluResult = 32'd0;
`ifdef MULDIV_EN
        if (B != 32'd0) begin
          LO_OUT = qs;
          HI_OUT = rs;
        end
`endif
      end
      OP_DIVU: begin
        aluResult = 32'd0;
`ifdef MULDIV_EN
        if (B != 32'd0) begin
          LO_OUT = qu;
          HI_OUT = ru;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OverflowSticky <= 1'b0;
    end else if (Overflow) begin
      OverflowSticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [5:0]  ALU_control = '0;
  logic [4:0]  shiftAmount = '0;
  logic [31:0] HI_IN = '0;
  logic [31:0] LO_IN = '0;
  logic [31:0] aluResult;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;
  logic        Overflow;
  logic        OverflowSticky;

  int n_cmp = 0;
  int n_fail = 0;

  mips_alu dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .ALU_control(ALU_control),
    .shiftAmount(shiftAmount), .HI_IN(HI_IN), .LO_IN(LO_IN),
    .aluResult(aluResult), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT),
    .Overflow(Overflow), .OverflowSticky(OverflowSticky)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain 64-bit integer arithmetic on the operation rules.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] r, output logic [31:0] h, output logic [31:0] l,
                                output logic v);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          s;
    longint unsigned u;
    logic [63:0]     w;
    r = a + b; h = hi; l = lo; v = 1'b0;
    case (op)
      6'b100000: begin s = sa + sb; w = s; r = w[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'b100001: begin u = ua + ub; w = u; r = w[31:0]; end
      6'b100010: begin s = sa - sb; w = s; r = w[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'b100011: begin s = sa - sb; w = s; r = w[31:0]; end
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: r = (ua < ub) ? 32'd1 : 32'd0;
      6'b000000: begin u = ub * (64'd1 << sh); w = u; r = w[31:0]; end
      6'b000010: begin u = ub / (64'd1 << sh); w = u; r = w[31:0]; end
      6'b000011: begin s = sb >>> sh; w = s; r = w[31:0]; end
      6'b000100: begin u = ub * (64'd1 << a[4:0]); w = u; r = w[31:0]; end
      6'b000110: begin u = ub / (64'd1 << a[4:0]); w = u; r = w[31:0]; end
      6'b000111: begin s = sb >>> a[4:0]; w = s; r = w[31:0]; end
      6'b001111: begin u = (ub % 65536) * 65536; w = u; r = w[31:0]; end
      6'b111111: r = b;
      6'b010000: r = hi;
      6'b010010: r = lo;
      6'b010001: begin r = 0; h = a; end
      6'b010011: begin r = 0; l = a; end
`ifdef MULDIV_EN
      6'b011000: begin r = 0; s = sa * sb; w = s; h = w[63:32]; l = w[31:0]; end
      6'b011001: begin r = 0; u = ua * ub; w = u; h = w[63:32]; l = w[31:0]; end
      6'b011010: begin
        r = 0;
        if (b != 0) begin s = sa / sb; w = s; l = w[31:0]; s = sa % sb; w = s; h = w[31:0]; end
      end
      6'b011011: begin
        r = 0;
        if (b != 0) begin u = ua / ub; w = u; l = w[31:0]; u = ua % ub; w = u; h = w[31:0]; end
      end
`else
      6'b011000, 6'b011001, 6'b011010, 6'b011011: r = 0;
`endif
      default: ;
    endcase
  endfunction

  task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo);
    @(negedge CLK);
    ALU_control = op; A = a; B = b; shiftAmount = sh; HI_IN = hi; LO_IN = lo;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    apply(6'b100000, 32'h7FFFFFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    @(negedge CLK); #1;
    n_cmp++; if (OverflowSticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", OverflowSticky); end
    n_cmp++; if (aluResult !== 32'h80000000) begin n_fail++; $display("FAIL reset_tracks_result: got %h want 80000000", aluResult); end
    n_cmp++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL reset_tracks_ovf: got %b want 1", Overflow); end
    apply(6'b100001, 32'd1, 32'd2, 5'd0, 32'd0, 32'd0);
    RESET = 1'b1;
  endtask

  task automatic test_sticky();
    apply(6'b100001, 32'h7FFFFFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL addu_no_ovf: got %b want 0", Overflow); end
    apply(6'b100000, 32'h7FFFFFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (OverflowSticky !== 1'b0) begin n_fail++; $display("FAIL sticky_pre_edge: got %b want 0", OverflowSticky); end
    n_cmp++; if (aluResult !== 32'h80000000 || Overflow !== 1'b1) begin n_fail++; $display("FAIL add_ovf: got %h/%b want 80000000/1", aluResult, Overflow); end
    apply(6'b100000, 32'd1, 32'd1, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (OverflowSticky !== 1'b1) begin n_fail++; $display("FAIL sticky_set: got %b want 1", OverflowSticky); end
    apply(6'b100010, 32'd5, 32'd3, 5'd0, 32'd0, 32'd0);
    apply(6'b100010, 32'd5, 32'd3, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (OverflowSticky !== 1'b1) begin n_fail++; $display("FAIL sticky_holds: got %b want 1", OverflowSticky); end
    // Asynchronous clear between edges.
    RESET = 1'b0; #1;
    n_cmp++; if (OverflowSticky !== 1'b0) begin n_fail++; $display("FAIL sticky_async_clear: got %b want 0", OverflowSticky); end
    RESET = 1'b1;
    apply(6'b100010, 32'h80000000, 32'd1, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (aluResult !== 32'h7FFFFFFF || Overflow !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: got %h/%b want 7fffffff/1", aluResult, Overflow); end
    RESET = 1'b0; #1; RESET = 1'b1;
  endtask

  task automatic test_directed();
    apply(6'b000011, 32'd0, 32'hF0000000, 5'd4, 32'd0, 32'd0);
    n_cmp++; if (aluResult !== 32'hFF000000) begin n_fail++; $display("FAIL sra: got %h want ff000000", aluResult); end
    apply(6'b000110, 32'd4, 32'hF0000000, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (aluResult !== 32'h0F000000) begin n_fail++; $display("FAIL srlv: got %h want 0f000000", aluResult); end
    apply(6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (aluResult !== 32'd1) begin n_fail++; $display("FAIL slt: got %h want 1", aluResult); end
    apply(6'b101011, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (aluResult !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h want 0", aluResult); end
    apply(6'b001000, 32'h1000, 32'd8, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (aluResult !== 32'h1008) begin n_fail++; $display("FAIL undefined_add: got %h want 1008", aluResult); end
    apply(6'b001111, 32'd0, 32'h1234, 5'd0, 32'd0, 32'd0);
    n_cmp++; if (aluResult !== 32'h12340000) begin n_fail++; $display("FAIL lui: got %h want 12340000", aluResult); end
    apply(6'b011011, 32'd99, 32'd0, 5'd0, 32'h11, 32'h22);
    n_cmp++; if (HI_OUT !== 32'h11 || LO_OUT !== 32'h22) begin n_fail++; $display("FAIL divu_by_zero: got %h/%h want 11/22", HI_OUT, LO_OUT); end
    apply(6'b010001, 32'hCAFE0001, 32'd0, 5'd0, 32'h11, 32'h22);
    n_cmp++; if (HI_OUT !== 32'hCAFE0001 || LO_OUT !== 32'h22 || aluResult !== 32'd0) begin n_fail++; $display("FAIL mthi: got %h/%h/%h want cafe0001/22/0", HI_OUT, LO_OUT, aluResult); end
    apply(6'b011000, 32'hFFFFFFFE, 32'd3, 5'd0, 32'hAAAA, 32'h5555);
`ifdef MULDIV_EN
    n_cmp++; if (HI_OUT !== 32'hFFFFFFFF || LO_OUT !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult: got %h/%h want ffffffff/fffffffa", HI_OUT, LO_OUT); end
    apply(6'b011001, 32'hFFFFFFFE, 32'd3, 5'd0, 32'hAAAA, 32'h5555);
    n_cmp++; if (HI_OUT !== 32'd2 || LO_OUT !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu: got %h/%h want 2/fffffffa", HI_OUT, LO_OUT); end
    apply(6'b011010, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hAAAA, 32'h5555);
    n_cmp++; if (HI_OUT !== 32'hFFFFFFFF || LO_OUT !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div: got %h/%h want ffffffff/fffffffd", HI_OUT, LO_OUT); end
    apply(6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'hAAAA, 32'h5555);
    n_cmp++; if (HI_OUT !== 32'd0 || LO_OUT !== 32'h80000000) begin n_fail++; $display("FAIL div_min_neg1: got %h/%h want 0/80000000", HI_OUT, LO_OUT); end
`else
    n_cmp++; if (HI_OUT !== 32'hAAAA || LO_OUT !== 32'h5555 || aluResult !== 32'd0) begin n_fail++; $display("FAIL mult_disabled: got %h/%h/%h want aaaa/5555/0", HI_OUT, LO_OUT, aluResult); end
    apply(6'b011010, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hAAAA, 32'h5555);
    n_cmp++; if (HI_OUT !== 32'hAAAA || LO_OUT !== 32'h5555 || aluResult !== 32'd0) begin n_fail++; $display("FAIL div_disabled: got %h/%h/%h want aaaa/5555/0", HI_OUT, LO_OUT, aluResult); end
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [0:31];
    logic [31:0] a, b, hi, lo, er, eh, el;
    logic [4:0]  sh;
    logic [5:0]  op;
    logic        ev;
    ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0F, 6'h3F, 6'h10, 6'h12,
            6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1A, 6'h1B, 6'h08, 6'h01,
            6'h30, 6'h2F};
    for (int i = 0; i < 500; i++) begin
      op = ops[$urandom_range(0, 31)];
      a = $urandom; b = $urandom; hi = $urandom; lo = $urandom;
      sh = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h80000000 | (a & 32'h3);
        2: b = 32'hFFFFFFFF - (b & 32'h3);
        3: begin a = a & 32'hFF; b = b & 32'hF; end
        default: ;
      endcase
      apply(op, a, b, sh, hi, lo);
      model(op, a, b, sh, hi, lo, er, eh, el, ev);
      n_cmp++;
      if ({aluResult, HI_OUT, LO_OUT, Overflow} !== {er, eh, el, ev}) begin
        n_fail++;
        $display("FAIL random op=%h a=%h b=%h sh=%0d: got r=%h hi=%h lo=%h v=%b want r=%h hi=%h lo=%h v=%b",
                 op, a, b, sh, aluResult, HI_OUT, LO_OUT, Overflow, er, eh, el, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sticky();
    test_directed();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
